// File: rtl/coreapb3_resp_mux.sv
// rtl/coreapb3_resp_mux.sv - APB3 slave response multiplexer with access watchdog
//
// Routes the selected slave's read data, ready and error back to the APB
// master. A watchdog detects a selected slave that holds PREADY low. When the
// slave stays unready for TIMEOUT_CYCLES access cycles, the watchdog ends the
// transfer with an error response.
//
// Ports:
//   PCLK, PRESETN    clock, asynchronous active-low reset
//   PSELS            one-hot slot select from the decoder
//   PENABLE          APB access phase
//   PRDATAS          packed per-slot read data, slot n at [n*DATA_WIDTH +: DATA_WIDTH]
//   PREADYS          per-slot ready
//   PSLVERRS         per-slot error
//   PREADY           muxed ready to the master
//   PSLVERR          muxed error to the master
//   PRDATA           muxed read data to the master
//   TO_CLR           pulse that clears TO_FLAG
//   TO_FLAG          sticky flag, set when a timeout has occurred
//   TO_SLOT          index of the slot that last timed out
module coreapb3_resp_mux #(
  parameter int NUM_SLOTS      = 17,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_EN     = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int NOSEL_ERR      = 0
) (
  input  logic                            PCLK,
  input  logic                            PRESETN,
  input  logic [NUM_SLOTS-1:0]            PSELS,
  input  logic                            PENABLE,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATAS,
  input  logic [NUM_SLOTS-1:0]            PREADYS,
  input  logic [NUM_SLOTS-1:0]            PSLVERRS,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            TO_CLR,
  output logic                            TO_FLAG,
  output logic [4:0]                      TO_SLOT
);

  localparam bit        TO_ENABLE  = (TIMEOUT_EN != 0);
  localparam bit        NOSEL_RESP = (NOSEL_ERR != 0);
  // The counter value reached at the edge that ends the last allowed unready cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic [4:0]            cur_idx_q, cur_idx_d;
  logic                  to_flag_q;
  logic [4:0]            to_slot_q;
  logic                  to_set;

  logic [5:0]            sel_cnt;
  logic [4:0]            sel_idx;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_none;
  logic                  sel_one;
  logic                  sel_multi;
  logic [15:0]           cnt_inc;

  // Slot decode. The loop also counts the set select bits, so a multi-select
  // can be flagged instead of OR-ing several slaves together.
  always_comb begin
    sel_cnt   = '0;
    sel_idx   = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    for (int n = 0; n < NUM_SLOTS; n++) begin
      if (PSELS[n]) begin
        sel_cnt   = sel_cnt + 6'd1;
        sel_idx   = 5'(n);
        sel_ready = PREADYS[n];
        sel_err   = PSLVERRS[n];
        sel_data  = PRDATAS[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_none  = (sel_cnt == 6'd0);
  assign sel_one   = (sel_cnt == 6'd1);
  assign sel_multi = (sel_cnt > 6'd1);
  assign cnt_inc   = wait_cnt_q + 16'd1;

  // Watchdog FSM next state. Only a clean single-slot access can stall.
  // Multi-select and no-select already complete at once with PREADY=1.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cur_idx_d  = cur_idx_q;
    to_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TO_ENABLE && sel_one && PENABLE && !sel_ready) begin
          state_d    = ST_ACCESS;
          wait_cnt_d = '0;
          cur_idx_d  = sel_idx;
        end
      end
      ST_ACCESS: begin
        // Dropped select, dropped enable or a different slot means the master
        // abandoned the transfer. A completing slave also ends it.
        if (!sel_one || !PENABLE || (sel_idx != cur_idx_q) || sel_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (cnt_inc >= CNT_LAST) begin
          state_d    = ST_TIMEOUT;
          wait_cnt_d = cnt_inc;
          to_set     = 1'b1;
        end else begin
          wait_cnt_d = cnt_inc;
        end
      end
      ST_TIMEOUT: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      cur_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cur_idx_q  <= cur_idx_d;
    end
  end

  // A new timeout beats a clear that arrives on the same edge.
  // A clear does not change TO_SLOT, so it keeps the last timed-out slot.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      to_flag_q <= 1'b0;
      to_slot_q <= '0;
    end else begin
      if (to_set) begin
        to_flag_q <= 1'b1;
        to_slot_q <= cur_idx_q;
      end else if (TO_CLR) begin
        to_flag_q <= 1'b0;
      end
    end
  end

  // Response mux. The TIMEOUT state overrides the slave, even if the slave
  // asserts ready in the same cycle. The PRESETN gate keeps reset from
  // exposing the forced response.
  always_comb begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if ((state_q == ST_TIMEOUT) && PRESETN) begin
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
    end else if (sel_none) begin
      PSLVERR = NOSEL_RESP;
    end else if (sel_multi) begin
      PSLVERR = 1'b1;
    end else begin
      PREADY  = sel_ready;
      PSLVERR = sel_err;
      PRDATA  = sel_data;
    end
  end

  assign TO_FLAG = to_flag_q;
  assign TO_SLOT = to_slot_q;

endmodule

// File: doc/coreapb3_resp_mux.md
COREAPB3_RESP_MUX -- requirements
Module: coreapb3_resp_mux

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 17, range 1..32, the number of APB slave slots.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, one of 8/16/32, the read-data width.
REQ-003 SHALL have parameter TIMEOUT_EN, default 1, where 1 enables the access watchdog.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, range 2..65535, the count of unready ACCESS cycles before forced completion.
REQ-005 SHALL have parameter NOSEL_ERR, default 0, the PSLVERR value returned for an access with no slot selected.
REQ-006 SHALL have port PCLK, input, 1 bit, the single clock; all state on rising edge.
REQ-007 SHALL have port PRESETN, input, 1 bit, reset that is asynchronous and active-low.
REQ-008 SHALL have port PSELS, input, NUM_SLOTS bits, one-hot slot select; bit n selects slot n.
REQ-009 SHALL have port PENABLE, input, 1 bit, the APB access phase.
REQ-010 SHALL have port PRDATAS, input, NUM_SLOTS*DATA_WIDTH bits, where slot n occupies [n*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port PREADYS, input, NUM_SLOTS bits, per-slot ready.
REQ-012 SHALL have port PSLVERRS, input, NUM_SLOTS bits, per-slot error.
REQ-013 SHALL have port PREADY, output, 1 bit, the muxed ready to the master.
REQ-014 SHALL have port PSLVERR, output, 1 bit, the muxed error to the master.
REQ-015 SHALL have port PRDATA, output, DATA_WIDTH bits, the muxed read data.
REQ-016 SHALL have port TO_CLR, input, 1 bit, a pulse that clears the timeout status.
REQ-017 SHALL have port TO_FLAG, output, 1 bit, the sticky timeout-occurred flag.
REQ-018 SHALL have port TO_SLOT, output, 5 bits, the index of the slot that last timed out.

Function
REQ-019 SHALL route, when exactly one PSELS bit n is set and the FSM is not in TIMEOUT, slot n PRDATA/PREADY/PSLVERR to the outputs combinationally with zero latency.
REQ-020 SHALL drive PRDATA=0, PREADY=1 and PSLVERR=NOSEL_ERR when PSELS is all zero.
REQ-021 SHALL drive PRDATA=0, PREADY=1 and PSLVERR=1 when PSELS has more than one bit set (illegal multi-select).
REQ-022 SHALL implement FSM states IDLE, ACCESS and TIMEOUT.
REQ-023 SHALL transition IDLE->ACCESS on the edge where (|PSELS & PENABLE & selected PREADYS=0 & TIMEOUT_EN=1).
REQ-024 SHALL keep a 16-bit wait counter that clears on entry to ACCESS and increments each ACCESS cycle while selected PREADYS=0.
REQ-025 SHALL transition ACCESS->IDLE when selected PREADYS=1, or PSELS=0, or PENABLE=0 (abandoned transfer); the counter SHALL clear.
REQ-026 SHALL transition ACCESS->TIMEOUT when the counter reaches TIMEOUT_CYCLES-1 while selected PREADYS=0.
REQ-027 SHALL, in TIMEOUT, force PREADY=1, PSLVERR=1 and PRDATA=0 regardless of slave inputs, including when PREADYS rises in that same cycle (timeout wins).
REQ-028 SHALL transition TIMEOUT->IDLE unconditionally after one cycle.
REQ-029 SHALL, on the ACCESS->TIMEOUT edge, set TO_FLAG=1 and load TO_SLOT with the encoded index of the selected slot.
REQ-030 SHALL clear TO_FLAG on TO_CLR=1; a set on the same edge SHALL win over the clear, and TO_SLOT SHALL retain its value on clear.
REQ-031 SHALL, with TIMEOUT_EN=0, remain in IDLE so that outputs are purely combinational per REQ-019..021.
REQ-032 SHALL treat a change of selected slot during ACCESS as abandonment and return to IDLE with the counter cleared.

Reset
REQ-033 SHALL, with PRESETN=0, immediately force FSM=IDLE, counter=0, TO_FLAG=0 and TO_SLOT=0, with no clock required.
REQ-034 SHALL hold combinational outputs to follow REQ-019..021 during reset, never forced TIMEOUT values.
REQ-035 SHALL abort a transfer when reset is asserted mid-ACCESS, and the first post-reset transfer SHALL start a fresh count.

Verification
REQ-036 SHALL pass a bench where, with PSELS=1<<5, PENABLE=1, PREADYS[5]=1, PRDATAS slot5=0xA5A5_1234 and PSLVERRS[5]=1 in the same cycle, PRDATA=0xA5A5_1234, PREADY=1 and PSLVERR=1.
REQ-037 SHALL pass a bench where PSELS=0 with NOSEL_ERR=0 gives PRDATA=0, PREADY=1 and PSLVERR=0, and PSELS=0x00003 gives PREADY=1 and PSLVERR=1.
REQ-038 SHALL pass a bench where, with TIMEOUT_CYCLES=4 and slot 16 never ready, PREADY=0 on access cycles 1..4, cycle 5 gives PREADY=1, PSLVERR=1 and PRDATA=0, then TO_FLAG=1 and TO_SLOT=16.
REQ-039 SHALL pass a bench where, with TIMEOUT_CYCLES=4, slot 2 ready on access cycle 4 completes normally with PSLVERR=PSLVERRS[2] and TO_FLAG stays 0.
REQ-040 SHALL pass a bench where TO_CLR pulsed on the same edge as a new timeout leaves TO_FLAG=1, and a later TO_CLR alone gives TO_FLAG=0 with TO_SLOT unchanged.
REQ-041 SHALL pass a bench where PRESETN is asserted at access cycle 3 of a stalled transfer with the FSM at IDLE and TO_FLAG=0, and after release a stalled transfer times out only after the full 4 cycles.
